cam_array_param: RTL and testbench

//  Parametrised content-addressable memory: DEPTH entries of DATA_W bits, each with a valid bit.

---
 rtl/cam_array_param.sv | 186 ++++++++++++++++++
 tb/tb_cam_array_param.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_array_param.sv
// cam_array_param: DEPTH x DATA_W content-addressable memory with per-entry valid bits
// and a single search/write/invalidate command port. Define CAM_MASK_EN for per-entry don't-care masks.
module cam_array_param #(
    parameter int  DATA_W = 7,
    parameter int  DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [ADDR_W-1:0] cmd_addr,
`ifdef CAM_MASK_EN
    input  logic [DATA_W-1:0] cmd_mask,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic              rsp_multi,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DEPTH-1:0]  rsp_match_vec,
    output logic [ADDR_W:0]   occupancy,
    output logic              full
);

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;
    typedef enum logic [1:0] {
        OP_SEARCH  = 2'b00,
        OP_WR_NEXT = 2'b01,
        OP_WR_AT   = 2'b10,
        OP_INVAL   = 2'b11
    } op_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef CAM_MASK_EN
    logic [DATA_W-1:0] r_mask [DEPTH];
`endif
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_rr_ptr;
    logic [DATA_W-1:0] r_key;
    logic              r_hit;
    logic              r_multi;
    logic [ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0]  r_vec;
    logic [ADDR_W:0]   r_occ;

    op_t               w_op;
    logic              w_accept;
    logic              w_addr_ok;
    logic              w_all_valid;
    logic              w_free_found;
    logic [ADDR_W-1:0] w_free_idx;
    logic [DEPTH-1:0]  w_match;
    logic              w_hit_found;
    logic [ADDR_W-1:0] w_hit_idx;
    logic              w_multi;
    logic [ADDR_W:0]   w_count;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_idx;

    assign w_op        = op_t'(cmd_op);
    assign cmd_ready   = (r_state == S_IDLE);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_addr_ok   = ({1'b0, cmd_addr} < (ADDR_W+1)'(DEPTH));
    assign w_all_valid = &r_valid;
    assign w_multi     = ((w_match & (w_match - DEPTH'(1))) != '0);

    always_comb begin
        w_match      = '0;
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_count      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef CAM_MASK_EN
            w_match[i] = r_valid[i] & (((r_mem[i] ^ r_key) & ~r_mask[i]) == '0);
`else
            w_match[i] = r_valid[i] & (r_mem[i] == r_key);
`endif
            if (w_match[i] && !w_hit_found) begin
                w_hit_found = 1'b1;
                w_hit_idx   = ADDR_W'(i);
            end
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = ADDR_W'(i);
            end
            w_count = w_count + (ADDR_W+1)'(r_valid[i]);
        end
    end

    // write-next fills the lowest hole first; only a full array falls back to round-robin replacement
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        if (w_accept) begin
            case (w_op)
                OP_WR_NEXT: begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_all_valid ? r_rr_ptr : w_free_idx;
                end
                OP_WR_AT: begin
                    w_wr_en  = w_addr_ok;
                    w_wr_idx = cmd_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (w_op == OP_SEARCH)) w_state_nxt = S_CMP;
            S_CMP:   w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
`ifdef CAM_MASK_EN
                r_mask[i] <= '0;
`endif
            end
            r_valid  <= '0;
            r_rr_ptr <= '0;
            r_key    <= '0;
            r_hit    <= 1'b0;
            r_multi  <= 1'b0;
            r_addr   <= '0;
            r_vec    <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[w_wr_idx]   <= cmd_data;
`ifdef CAM_MASK_EN
                r_mask[w_wr_idx]  <= cmd_mask;
`endif
                r_valid[w_wr_idx] <= 1'b1;
            end
            if (w_accept && (w_op == OP_WR_NEXT) && w_all_valid) begin
                r_rr_ptr <= (r_rr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_rr_ptr + ADDR_W'(1);
            end
            if (w_accept && (w_op == OP_INVAL) && w_addr_ok) begin
                r_valid[cmd_addr] <= 1'b0;
            end
            if (w_accept && (w_op == OP_SEARCH)) begin
                r_key <= cmd_data;
            end
            if (r_state == S_CMP) begin
                r_hit   <= w_hit_found;
                r_multi <= w_multi;
                r_addr  <= w_hit_idx;
                r_vec   <= w_match;
            end
            r_occ <= w_count;
        end
    end

    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_hit       = r_hit;
    assign rsp_multi     = r_multi;
    assign rsp_addr      = r_addr;
    assign rsp_match_vec = r_vec;
    assign occupancy     = r_occ;
    assign full          = (r_occ == (ADDR_W+1)'(DEPTH));

endmodule

// File: tb/tb_cam_array_param.sv
// Scoreboard bench for cam_array_param (16 x 7); expected search results are queued when each
// search is issued and compared when the response appears.
module tb_cam_array_param;

    localparam int DATA_W = 7;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam logic [1:0] OP_SEARCH  = 2'b00;
    localparam logic [1:0] OP_WR_NEXT = 2'b01;
    localparam logic [1:0] OP_WR_AT   = 2'b10;
    localparam logic [1:0] OP_INVAL   = 2'b11;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op    = '0;
    logic [DATA_W-1:0] cmd_data  = '0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [DATA_W-1:0] cmd_mask  = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_hit;
    logic              rsp_multi;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DEPTH-1:0]  rsp_match_vec;
    logic [ADDR_W:0]   occupancy;
    logic              full;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic              hit;
        logic              multi;
        logic [ADDR_W-1:0] addr;
        logic [DEPTH-1:0]  vec;
    } rsp_t;

    rsp_t exp_q[$];

    always #5 clk = ~clk;

    cam_array_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .cmd_addr      (cmd_addr),
`ifdef CAM_MASK_EN
        .cmd_mask      (cmd_mask),
`endif
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_multi     (rsp_multi),
        .rsp_addr      (rsp_addr),
        .rsp_match_vec (rsp_match_vec),
        .occupancy     (occupancy),
        .full          (full)
    );

    function automatic rsp_t mk(input logic h, input logic m, input logic [ADDR_W-1:0] a,
                                input logic [DEPTH-1:0] v);
        rsp_t r;
        r.hit   = h;
        r.multi = m;
        r.addr  = a;
        r.vec   = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] data,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] mask);
        int unsigned n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_addr  = addr;
        cmd_mask  = mask;
        tick();
        cmd_valid = 1'b0;
        cmd_mask  = '0;
    endtask

    task automatic search(input logic [DATA_W-1:0] key, input rsp_t exp, input bit chk_lat);
        rsp_t        got;
        rsp_t        e;
        int unsigned n = 0;
        exp_q.push_back(exp);
        send(OP_SEARCH, key, '0, '0);
        if (chk_lat) begin
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL lat_early: rsp_valid=%b required 0 one edge after accept", rsp_valid);
            end
        end
        while (rsp_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (chk_lat) begin
            total++;
            if (n !== 1) begin
                bad++;
                $display("FAIL lat_edges: response after %0d edges required 2", n + 1);
            end
        end
        e = exp_q.pop_front();
        if (rsp_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: key=%h rsp_valid=%b required 1", key, rsp_valid);
            return;
        end
        got = mk(rsp_hit, rsp_multi, rsp_addr, rsp_match_vec);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL search_%h: hit=%b multi=%b addr=%0d vec=%h required hit=%b multi=%b addr=%0d vec=%h",
                     key, got.hit, got.multi, got.addr, got.vec, e.hit, e.multi, e.addr, e.vec);
        end
        tick();
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rsp_pop: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic check_occ(input string name, input logic [ADDR_W:0] exp_occ, input logic exp_full);
        total++;
        if ({occupancy, full} !== {exp_occ, exp_full}) begin
            bad++;
            $display("FAIL %s: occupancy=%0d full=%b required %0d %b", name, occupancy, full, exp_occ, exp_full);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({cmd_ready, rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_match_vec, occupancy, full} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b hit=%b multi=%b addr=%0d vec=%h occ=%0d full=%b required 1 0 0 0 0 0000 0 0",
                     cmd_ready, rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_match_vec, occupancy, full);
        end
        rst_n = 1'b1;
        search(7'h00, mk(1'b0, 1'b0, 4'd0, 16'h0000), 1'b1);
        check_occ("reset_occ", 5'd0, 1'b0);
    endtask

    task automatic test_write_search();
        send(OP_WR_NEXT, 7'h11, '0, '0);
        send(OP_WR_NEXT, 7'h22, '0, '0);
        send(OP_WR_NEXT, 7'h33, '0, '0);
        check_occ("occ_lag", 5'd2, 1'b0);
        tick();
        check_occ("occ_three", 5'd3, 1'b0);
        search(7'h22, mk(1'b1, 1'b0, 4'd1, 16'h0002), 1'b1);
    endtask

    task automatic test_fill_overwrite();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send(OP_WR_NEXT, DATA_W'(7'h40 + i), '0, '0);
        end
        tick();
        check_occ("fill_full", 5'd16, 1'b1);
        send(OP_WR_NEXT, 7'h7F, '0, '0);
        send(OP_WR_NEXT, 7'h7F, '0, '0);
        tick();
        check_occ("overwrite_full", 5'd16, 1'b1);
        search(7'h7F, mk(1'b1, 1'b1, 4'd0, 16'h0003), 1'b0);
        search(7'h40, mk(1'b0, 1'b0, 4'd0, 16'h0000), 1'b0);
        search(7'h41, mk(1'b0, 1'b0, 4'd0, 16'h0000), 1'b0);
        search(7'h42, mk(1'b1, 1'b0, 4'd2, 16'h0004), 1'b0);
        send(OP_WR_NEXT, 7'h01, '0, '0);
        search(7'h01, mk(1'b1, 1'b0, 4'd2, 16'h0004), 1'b0);
        search(7'h42, mk(1'b0, 1'b0, 4'd0, 16'h0000), 1'b0);
    endtask

    task automatic test_duplicates();
        send(OP_WR_AT, 7'h0A, 4'd5, '0);
        send(OP_WR_AT, 7'h0A, 4'd9, '0);
        search(7'h0A, mk(1'b1, 1'b1, 4'd5, 16'h0220), 1'b0);
        send(OP_INVAL, '0, 4'd5, '0);
        tick();
        check_occ("inval_occ", 5'd15, 1'b0);
        search(7'h0A, mk(1'b1, 1'b0, 4'd9, 16'h0200), 1'b0);
        send(OP_INVAL, '0, 4'd5, '0);
        tick();
        check_occ("inval_twice", 5'd15, 1'b0);
        send(OP_WR_NEXT, 7'h33, '0, '0);
        search(7'h33, mk(1'b1, 1'b0, 4'd5, 16'h0020), 1'b0);
    endtask

    task automatic test_hold_reset();
        int unsigned n = 0;
        rsp_ready = 1'b0;
        send(OP_SEARCH, 7'h33, '0, '0);
        while (rsp_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_WR_AT;
            cmd_data  = 7'h55;
            cmd_addr  = 4'd0;
            total++;
            if ({rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_match_vec, cmd_ready} !==
                {1'b1, 1'b1, 1'b0, 4'd5, 16'h0020, 1'b0}) begin
                bad++;
                $display("FAIL hold_%0d: valid=%b hit=%b multi=%b addr=%0d vec=%h ready=%b required 1 1 0 5 0020 0",
                         k, rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_match_vec, cmd_ready);
            end
            tick();
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        tick();
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL hold_reset: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        exp_q.delete();
        search(7'h55, mk(1'b0, 1'b0, 4'd0, 16'h0000), 1'b0);

        send(OP_WR_AT, 7'h12, 4'd0, '0);
        send(OP_SEARCH, 7'h12, '0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL abort_%0d: rsp_valid=%b required 0", k, rsp_valid);
            end
            tick();
        end
        check_occ("abort_occ", 5'd0, 1'b0);
    endtask

`ifdef CAM_MASK_EN
    task automatic test_mask();
        do_reset();
        send(OP_WR_AT, 7'h50, 4'd3, 7'h0F);
        search(7'h5A, mk(1'b1, 1'b0, 4'd3, 16'h0008), 1'b0);
        search(7'h6A, mk(1'b0, 1'b0, 4'd0, 16'h0000), 1'b0);
        search(7'h50, mk(1'b1, 1'b0, 4'd3, 16'h0008), 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_search();
        test_fill_overwrite();
        test_duplicates();
        test_hold_reset();
`ifdef CAM_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
